// File: rtl/relu_bp_sched.sv
// relu_bp_sched: ReLU backprop sequencer, streams z/delta pairs and writes gated deltas.
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start               run request, sampled only while idle
//   busy, done          run in progress / one-cycle end-of-run pulse
//   rd_en, rd_addr      shared read strobe and address for the z and delta memories
//   z_rd_data, d_rd_data  memory words, valid the cycle after rd_en
//   wr_en, wr_addr, wr_data  gated-delta write port, two cycles behind the read
//   zero_cnt            number of elements gated to zero in the last run
module relu_bp_sched #(
    parameter int NBITS  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [NBITS-1:0]  z_rd_data,
    input  logic [NBITS-1:0]  d_rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [NBITS-1:0]  wr_data,
    output logic [ADDR_W:0]   zero_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    state_t            state;
    logic              drain_cnt;
    logic              v1;
    logic [ADDR_W-1:0] a1;
    logic              neg;
    assign neg = z_rd_data[NBITS-1];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            v1        <= 1'b0;
            a1        <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            zero_cnt  <= '0;
        end else begin
            // v1/a1 track the read whose data arrives this cycle
            v1    <= rd_en;
            a1    <= rd_addr;
            wr_en <= v1;
            if (v1) begin
                wr_addr <= a1;
                wr_data <= neg ? '0 : d_rd_data;
            end
            zero_cnt <= (state == IDLE && start) ? '0 : zero_cnt + (ADDR_W+1)'(v1 & neg);
            case (state)
                IDLE: if (start) begin
                    state   <= ISSUE;
                    busy    <= 1'b1;
                    rd_en   <= 1'b1;
                    rd_addr <= '0;
                end
                ISSUE: if (rd_addr == LAST) begin
                    state     <= DRAIN;
                    rd_en     <= 1'b0;
                    drain_cnt <= 1'b0;
                end else
                    rd_addr <= rd_addr + 1'b1;
                // two cycles for the last read's data and result register
                DRAIN: begin
                    drain_cnt <= ~drain_cnt;
                    if (drain_cnt) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_relu_bp_sched.sv
// tb_relu_bp_sched: directed self-checking bench for relu_bp_sched.
module tb_relu_bp_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, rd_en, wr_en;
    logic [2:0]  rd_addr, wr_addr;
    logic [15:0] z_rd_data = '0, d_rd_data = '0, wr_data;
    logic [3:0]  zero_cnt;
    logic [15:0] zmem [8];
    logic [15:0] dmem [8];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    relu_bp_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .z_rd_data(z_rd_data), .d_rd_data(d_rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .zero_cnt(zero_cnt)
    );

    always @(posedge clk)
        if (rd_en) begin
            z_rd_data <= zmem[rd_addr];
            d_rd_data <= dmem[rd_addr];
        end

    task load_basic;
        zmem = '{16'd100, 16'hFFFB, 16'h0000, 16'hFF00, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
        for (int i = 0; i < 8; i++) dmem[i] = 16'h0100;
    endtask

    task test_reset;
        #2;
        total++;
        if ({busy, done, rd_en, wr_en} !== 4'b0 || rd_addr !== 3'd0 || wr_addr !== 3'd0 || wr_data !== 16'd0 || zero_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset got busy=%b done=%b rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d wr_data=%h zero_cnt=%0d exp all 0",
                     busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data, zero_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || rd_en !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle busy=%b rd_en=%b exp 0 0", busy, rd_en);
            end
        end
    endtask

    task test_basic;
        logic [15:0] ew [8];
        int nw;
        ew = '{16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000};
        load_basic();
        nw = 0;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk) start = 1'b0;
            total++;
            if (busy !== (c <= 11)) begin
                bad++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy, c <= 11);
            end
            total++;
            if (rd_en !== (c <= 8)) begin
                bad++; $display("FAIL basic_rd_en c=%0d got=%b exp=%b", c, rd_en, c <= 8);
            end
            if (c <= 8) begin
                total++;
                if (rd_addr !== 3'(c - 1)) begin
                    bad++; $display("FAIL basic_rd_addr c=%0d got=%0d exp=%0d", c, rd_addr, c - 1);
                end
            end
            total++;
            if (wr_en !== (c >= 3 && c <= 10)) begin
                bad++; $display("FAIL basic_wr_en c=%0d got=%b exp=%b", c, wr_en, c >= 3 && c <= 10);
            end
            if (wr_en) nw++;
            if (c >= 3 && c <= 10) begin
                total++;
                if (wr_addr !== 3'(c - 3) || wr_data !== ew[c-3]) begin
                    bad++; $display("FAIL basic_write c=%0d got addr=%0d data=%h exp addr=%0d data=%h", c, wr_addr, wr_data, c - 3, ew[c-3]);
                end
            end
            total++;
            if (done !== (c == 11)) begin
                bad++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, done, c == 11);
            end
            if (c == 11) begin
                total++;
                if (zero_cnt !== 4'd4) begin
                    bad++; $display("FAIL basic_zero_cnt got=%0d exp=4", zero_cnt);
                end
            end
        end
        total++;
        if (nw != 8) begin
            bad++; $display("FAIL basic_nwrites got=%0d exp=8", nw);
        end
    endtask

    task test_sign_edge;
        for (int i = 0; i < 8; i++) begin
            zmem[i] = 16'h0000;
            dmem[i] = 16'hABCD;
        end
        zmem[0] = 16'h8000;
        zmem[1] = 16'h7FFF;
        total++;
        if (zero_cnt !== 4'd4) begin
            bad++; $display("FAIL hold_zero_cnt got=%0d exp=4", zero_cnt);
        end
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk) start = 1'b0;
            if (c == 3) begin
                total++;
                if (wr_en !== 1'b1 || wr_addr !== 3'd0 || wr_data !== 16'h0000) begin
                    bad++; $display("FAIL sign_neg got en=%b addr=%0d data=%h exp en=1 addr=0 data=0000", wr_en, wr_addr, wr_data);
                end
            end
            if (c == 4) begin
                total++;
                if (wr_en !== 1'b1 || wr_addr !== 3'd1 || wr_data !== 16'hABCD) begin
                    bad++; $display("FAIL sign_pos got en=%b addr=%0d data=%h exp en=1 addr=1 data=abcd", wr_en, wr_addr, wr_data);
                end
            end
            if (c == 5) begin
                total++;
                if (wr_data !== 16'hABCD) begin
                    bad++; $display("FAIL sign_zero_z got data=%h exp=abcd", wr_data);
                end
            end
            if (c == 11) begin
                total++;
                if (done !== 1'b1 || zero_cnt !== 4'd1) begin
                    bad++; $display("FAIL sign_done got done=%b zero_cnt=%0d exp done=1 zero_cnt=1", done, zero_cnt);
                end
            end
        end
    endtask

    task test_start_during_busy;
        int nw, nd;
        load_basic();
        nw = 0;
        nd = 0;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk) start = (c == 5);
            if (wr_en) nw++;
            if (done) nd++;
            if (c == 11) begin
                total++;
                if (done !== 1'b1) begin
                    bad++; $display("FAIL busy_start_done c=11 got=%b exp=1", done);
                end
            end
            if (c == 12) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++; $display("FAIL busy_start_busy c=12 got=%b exp=0", busy);
                end
            end
        end
        total++;
        if (nw != 8 || nd != 1) begin
            bad++; $display("FAIL busy_start_counts got writes=%0d dones=%0d exp 8 1", nw, nd);
        end
    endtask

    task test_back_to_back;
        load_basic();
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 13) start = 1'b0;
            total++;
            if (done !== (c == 11 || c == 23)) begin
                bad++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done, c == 11 || c == 23);
            end
            if (c == 12) begin
                total++;
                if (busy !== 1'b0 || zero_cnt !== 4'd4) begin
                    bad++; $display("FAIL b2b_gap got busy=%b zero_cnt=%0d exp 0 4", busy, zero_cnt);
                end
            end
            if (c == 13) begin
                total++;
                if (zero_cnt !== 4'd0 || rd_en !== 1'b1 || rd_addr !== 3'd0) begin
                    bad++; $display("FAIL b2b_restart got zero_cnt=%0d rd_en=%b rd_addr=%0d exp 0 1 0", zero_cnt, rd_en, rd_addr);
                end
            end
            if (c == 23) begin
                total++;
                if (zero_cnt !== 4'd4) begin
                    bad++; $display("FAIL b2b_zero_cnt2 got=%0d exp=4", zero_cnt);
                end
            end
        end
    endtask

    task test_mid_reset;
        int nw;
        logic [2:0] ea;
        load_basic();
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 6; c++) @(negedge clk) start = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, rd_en, wr_en} !== 3'b0 || zero_cnt !== 4'd0) begin
            bad++; $display("FAIL midrst_async got busy=%b rd_en=%b wr_en=%b zero_cnt=%0d exp all 0", busy, rd_en, wr_en, zero_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        nw = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rd_en || wr_en || busy) nw++;
        end
        total++;
        if (nw != 0) begin
            bad++; $display("FAIL midrst_quiet got active_cycles=%0d exp=0", nw);
        end
        start = 1'b1;
        nw = 0;
        ea = 3'd0;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk) start = 1'b0;
            if (c == 1) begin
                total++;
                if (rd_en !== 1'b1) begin
                    bad++; $display("FAIL midrst_first_start got rd_en=%b exp=1", rd_en);
                end
            end
            if (wr_en) begin
                total++;
                if (wr_addr !== ea) begin
                    bad++; $display("FAIL midrst_order got addr=%0d exp=%0d", wr_addr, ea);
                end
                ea++;
                nw++;
            end
        end
        total++;
        if (nw != 8) begin
            bad++; $display("FAIL midrst_nwrites got=%0d exp=8", nw);
        end
    endtask

    task test_all_positive;
        for (int i = 0; i < 8; i++) begin
            zmem[i] = 16'(i * 1000 + 1);
            dmem[i] = 16'(i * 16'h1111 + 3);
        end
        zmem[7] = 16'h7FFF;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk) start = 1'b0;
            if (c >= 3 && c <= 10) begin
                total++;
                if (wr_en !== 1'b1 || wr_data !== 16'((c - 3) * 16'h1111 + 3)) begin
                    bad++; $display("FAIL allpos_write c=%0d got en=%b data=%h exp en=1 data=%h", c, wr_en, wr_data, 16'((c - 3) * 16'h1111 + 3));
                end
            end
            if (c == 11) begin
                total++;
                if (zero_cnt !== 4'd0) begin
                    bad++; $display("FAIL allpos_zero_cnt got=%0d exp=0", zero_cnt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign_edge();
        test_start_during_busy();
        test_back_to_back();
        test_mid_reset();
        test_all_positive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
